// File: rtl/requant_pkg.sv
// Shared constants and saturation-bound helpers for the requant_n datapath.
package requant_pkg;

  localparam int unsigned IN_NUM_DEF   = 2;
  localparam int unsigned IN_SIZE_DEF  = 16;
  localparam int unsigned OUT_SIZE_DEF = 8;
  localparam int unsigned CNT_W_DEF    = 16;

  typedef enum logic {
    STAGE_ROUND = 1'b0,
    STAGE_SAT   = 1'b1
  } stage_e;

  function automatic int sat_max(int unsigned out_size);
    return int'(1 << (out_size - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned out_size);
    return -int'(1 << (out_size - 1));
  endfunction

endpackage

// File: rtl/round_sat_lane.sv
// One lane of requantization: either round-half-up arithmetic right shift, or signed saturation.
module round_sat_lane
  import requant_pkg::*;
#(
  parameter int unsigned IN_SIZE  = IN_SIZE_DEF,
  parameter int unsigned OUT_SIZE = OUT_SIZE_DEF,
  parameter int unsigned SHIFT_W  = $clog2(IN_SIZE),
  parameter stage_e      STAGE    = STAGE_ROUND,
  parameter int unsigned Q_W      = (STAGE == STAGE_ROUND) ? IN_SIZE + 1 : OUT_SIZE
) (
  input  logic signed [IN_SIZE:0]   d_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic signed [Q_W-1:0]     q_o,
  output logic                      sat_o
);

  localparam int unsigned W1 = IN_SIZE + 1;

  if (STAGE == STAGE_ROUND) begin : g_round
    logic signed [IN_SIZE:0] rnd;
    logic signed [IN_SIZE:0] sum;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
      rnd = '0;
      if (shift_i != '0) rnd = W1'(1) << (shift_i - SHIFT_W'(1));
      sum   = d_i + rnd;
      q_o   = sum >>> shift_i;
      sat_o = 1'b0;
    end
  end else begin : g_sat
    localparam logic signed [IN_SIZE:0] MAXV = W1'(sat_max(OUT_SIZE));
    localparam logic signed [IN_SIZE:0] MINV = W1'(sat_min(OUT_SIZE));
    logic unused_shift;

    assign unused_shift = ^shift_i;

    always_comb begin
      q_o   = d_i[OUT_SIZE-1:0];
      sat_o = 1'b0;
      if (d_i > MAXV) begin
        q_o   = MAXV[OUT_SIZE-1:0];
        sat_o = 1'b1;
      end else if (d_i < MINV) begin
        q_o   = MINV[OUT_SIZE-1:0];
        sat_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/requant_n.sv
// Two-stage valid/ready requantizer: per-lane round+shift, then saturate, with a sticky saturation counter.
module requant_n
  import requant_pkg::*;
#(
  parameter int unsigned IN_NUM   = IN_NUM_DEF,
  parameter int unsigned IN_SIZE  = IN_SIZE_DEF,
  parameter int unsigned OUT_SIZE = OUT_SIZE_DEF,
  parameter int unsigned SHIFT_W  = $clog2(IN_SIZE),
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_i [IN_NUM],
  input  logic [SHIFT_W-1:0]  shift_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_SIZE-1:0] out_o [IN_NUM],
  output logic [IN_NUM-1:0]   sat_o,
  output logic [CNT_W-1:0]    sat_cnt_o,
  input  logic                sat_clr_i
);

  logic                    s1_valid_q;
  logic signed [IN_SIZE:0] s1_data_q [IN_NUM];
  logic signed [IN_SIZE:0] s1_data_d [IN_NUM];
  logic                    out_valid_q;
  logic [OUT_SIZE-1:0]     out_q [IN_NUM];
  logic [OUT_SIZE-1:0]     out_d [IN_NUM];
  logic [IN_NUM-1:0]       sat_q, sat_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IN_NUM-1:0]       unused_rnd_sat;
  logic [SHIFT_W-1:0]      shift_c;
  logic                    s2_adv, s1_to_s2, in_fire, out_fire;

  assign s2_adv     = !out_valid_q | out_ready_i;
  assign s1_to_s2   = s1_valid_q & s2_adv;
  assign in_ready_o = !s1_valid_q | s1_to_s2;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_q & out_ready_i;

  assign shift_c = (32'(shift_i) >= IN_SIZE) ? SHIFT_W'(IN_SIZE - 1) : shift_i;

  for (genvar i = 0; i < IN_NUM; i++) begin : g_lane
    round_sat_lane #(
      .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .SHIFT_W(SHIFT_W), .STAGE(STAGE_ROUND)
    ) u_rnd (
      .d_i    ({in_i[i][IN_SIZE-1], in_i[i]}),
      .shift_i(shift_c),
      .q_o    (s1_data_d[i]),
      .sat_o  (unused_rnd_sat[i])
    );

    round_sat_lane #(
      .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .SHIFT_W(SHIFT_W), .STAGE(STAGE_SAT)
    ) u_sat (
      .d_i    (s1_data_q[i]),
      .shift_i('0),
      .q_o    (out_d[i]),
      .sat_o  (sat_d[i])
    );
  end

  // Counter sticks at all-ones; a clear takes priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr_i) begin
      cnt_d = '0;
    end else if (out_fire && (|sat_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '{default: '0};
      out_valid_q <= 1'b0;
      out_q       <= '{default: '0};
      sat_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (in_ready_o) s1_valid_q <= in_valid_i;
      if (in_fire) s1_data_q <= s1_data_d;
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s1_to_s2) begin
        out_q <= out_d;
        sat_q <= sat_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign sat_o       = sat_q;
  assign sat_cnt_o   = cnt_q;

endmodule

// File: tb/tb_requant_n.sv
// Randomized and directed bench for requant_n against a behavioural arithmetic model with a scoreboard.
module tb_requant_n;

  localparam int CMAX = 65535;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_i [2];
  logic [3:0]  shift_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_o [2];
  logic [1:0]  sat_o;
  logic [15:0] sat_cnt_o;
  logic        sat_clr_i;

  always #5 clk_i = ~clk_i;

  requant_n #(.IN_NUM(2), .IN_SIZE(16), .OUT_SIZE(8), .SHIFT_W(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_i(in_i), .shift_i(shift_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_o(out_o), .sat_o(sat_o), .sat_cnt_o(sat_cnt_o), .sat_clr_i(sat_clr_i)
  );

  typedef struct packed {
    logic [1:0][7:0] o;
    logic [1:0]      sat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;
  int   pops   = 0;
  int   sent   = 0;
  bit   prev_stall = 0;
  bit   prod_done;
  logic [7:0] prev_o0, prev_o1;
  logic [1:0] prev_sat;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  // Exact value of round(x / 2^sh) with halves rounded toward +inf.
  function automatic int lane_val(logic [15:0] x, int sh);
    int v, d, s;
    v = int'($signed(x));
    s = (sh > 15) ? 15 : sh;
    if (s > 0) begin
      d = 1 << s;
      v = v + d / 2;
      if (v >= 0) v = v / d;
      else v = -((-v + d - 1) / d);
    end
    return v;
  endfunction

  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic [3:0] sh);
    exp_t e;
    int   v;
    for (int j = 0; j < 2; j++) begin
      v = lane_val((j == 0) ? a : b, int'(sh));
      if (v > 127) begin
        e.o[j] = 8'h7F; e.sat[j] = 1'b1;
      end else if (v < -128) begin
        e.o[j] = 8'h80; e.sat[j] = 1'b1;
      end else begin
        e.o[j] = 8'(v); e.sat[j] = 1'b0;
      end
    end
    return e;
  endfunction

  // Scoreboard/compare process: looks at what the next rising edge will do.
  always @(negedge clk_i) begin
    exp_t e;
    bit   hs, hs_sat;
    if (!rst_ni) begin
      q.delete();
      mcnt       = 0;
      prev_stall = 0;
    end else begin
      hs     = out_valid_o && out_ready_i;
      hs_sat = 0;
      chk("in_ready", longint'(in_ready_o), (q.size() >= 2 && !out_ready_i) ? 0 : 1);
      chk("sat_cnt", longint'(sat_cnt_o), mcnt);
      if (prev_stall) begin
        chk("hold_valid", longint'(out_valid_o), 1);
        chk("hold_out0", longint'(out_o[0]), longint'(prev_o0));
        chk("hold_out1", longint'(out_o[1]), longint'(prev_o1));
        chk("hold_sat", longint'(sat_o), longint'(prev_sat));
      end
      if (out_valid_o) begin
        if (q.size() == 0) fail("spurious_out");
        else begin
          e = q[0];
          chk("out0", longint'(out_o[0]), longint'(e.o[0]));
          chk("out1", longint'(out_o[1]), longint'(e.o[1]));
          chk("sat", longint'(sat_o), longint'(e.sat));
          if (hs) begin
            void'(q.pop_front());
            pops++;
            hs_sat = (e.sat != 2'b00);
          end
        end
      end
      if (sat_clr_i) mcnt = 0;
      else if (hs_sat && mcnt < CMAX) mcnt++;
      if (in_valid_i && in_ready_o) q.push_back(model(in_i[0], in_i[1], shift_i));
      prev_stall = out_valid_o && !out_ready_i;
      prev_o0    = out_o[0];
      prev_o1    = out_o[1];
      prev_sat   = sat_o;
    end
  end

  task automatic send(logic [15:0] a, logic [15:0] b, logic [3:0] sh);
    bit ok = 0;
    in_i[0] = a; in_i[1] = b; shift_i = sh; in_valid_i = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      ok = in_ready_o;
      @(posedge clk_i); #1;
    end
    if (!ok) fail("send_accept");
    in_valid_i = 1'b0;
    sent++;
  endtask

  task automatic expect_next(string name, logic [7:0] o0, logic [7:0] o1, logic [1:0] s);
    bit seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_i);
      if (out_valid_o && out_ready_i) begin
        seen = 1;
        chk({name, "_o0"}, longint'(out_o[0]), longint'(o0));
        chk({name, "_o1"}, longint'(out_o[1]), longint'(o1));
        chk({name, "_sat"}, longint'(sat_o), longint'(s));
      end
      @(posedge clk_i); #1;
    end
    if (!seen) fail({name, "_arrive"});
  endtask

  initial begin
    int base_sent, base_pops;
    rst_ni = 1'b0; in_valid_i = 1'b0; in_i[0] = '0; in_i[1] = '0; shift_i = '0;
    out_ready_i = 1'b1; sat_clr_i = 1'b0;

    chk("model_rnd0", lane_val(16'h0123, 4), 18);
    chk("model_rnd1", lane_val(16'h0128, 4), 19);
    chk("model_neg", lane_val(16'hFFE8, 4), -1);
    chk("model_min", lane_val(16'h8000, 4), -2048);
    chk("model_sh15", lane_val(16'h7FFF, 15), 1);

    #3;
    chk("rst_valid", longint'(out_valid_o), 0);
    chk("rst_out0", longint'(out_o[0]), 0);
    chk("rst_sat", longint'(sat_o), 0);
    chk("rst_cnt", longint'(sat_cnt_o), 0);
    chk("rst_ready", longint'(in_ready_o), 1);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Rounding with explicit two-cycle latency.
    send(16'h0123, 16'h0128, 4'd4);
    @(negedge clk_i);
    chk("lat_first_edge", longint'(out_valid_o), 0);
    @(posedge clk_i); #1;
    chk("lat_second_edge", longint'(out_valid_o), 1);
    chk("round_o0", longint'(out_o[0]), 8'h12);
    chk("round_o1", longint'(out_o[1]), 8'h13);
    expect_next("round", 8'h12, 8'h13, 2'b00);

    send(16'hFFE8, 16'h0005, 4'd4);
    expect_next("neg", 8'hFF, 8'h00, 2'b00);
    send(16'hFFE8, 16'h0005, 4'd0);
    expect_next("zero_sh", 8'hE8, 8'h05, 2'b00);
    send(16'h7FFF, 16'h8000, 4'd4);
    expect_next("sat", 8'h7F, 8'h80, 2'b11);
    chk("sat_cnt_one", longint'(sat_cnt_o), 1);
    send(16'h7FFF, 16'h8000, 4'd15);
    expect_next("sh15", 8'h01, 8'hFF, 2'b00);

    // Backpressure: five beats against a stalled sink.
    out_ready_i = 1'b0;
    base_sent = sent; base_pops = pops; prod_done = 0;
    fork
      begin
        for (int b = 0; b < 5; b++)
          send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        prod_done = 1;
      end
    join_none
    repeat (10) @(posedge clk_i);
    #1;
    chk("bp_accepted", sent - base_sent, 2);
    chk("bp_ready_low", longint'(in_ready_o), 0);
    chk("bp_valid", longint'(out_valid_o), 1);
    out_ready_i = 1'b1;
    for (int k = 0; k < 100 && !prod_done; k++) @(posedge clk_i);
    if (!prod_done) fail("bp_producer");
    repeat (5) @(posedge clk_i);
    #1;
    chk("bp_drained", longint'(q.size()), 0);
    chk("bp_popped", pops - base_pops, 5);

    // Reset with both stages full.
    out_ready_i = 1'b0;
    send(16'h1000, 16'h2000, 4'd2);
    send(16'h3000, 16'h4000, 4'd2);
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid_o), 0);
    chk("mid_rst_out0", longint'(out_o[0]), 0);
    chk("mid_rst_out1", longint'(out_o[1]), 0);
    chk("mid_rst_sat", longint'(sat_o), 0);
    chk("mid_rst_cnt", longint'(sat_cnt_o), 0);
    chk("mid_rst_ready", longint'(in_ready_o), 1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1; out_ready_i = 1'b1;
    send(16'h0040, 16'hFFC0, 4'd3);
    expect_next("post_rst", 8'h08, 8'hF8, 2'b00);
    @(negedge clk_i);
    chk("post_rst_alone", longint'(out_valid_o), 0);
    @(posedge clk_i); #1;

    // Randomized traffic with random stalls and clears.
    for (int c = 0; c < 3000; c++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      in_i[0]     = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      in_i[1]     = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      shift_i     = 4'($urandom_range(0, 15));
      out_ready_i = ($urandom_range(0, 3) != 0);
      sat_clr_i   = ($urandom_range(0, 31) == 0);
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1; sat_clr_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("rand_drained", longint'(q.size()), 0);

    // Counter saturation, then a clear colliding with a saturating handshake.
    sat_clr_i = 1'b1;
    @(posedge clk_i); #1;
    sat_clr_i = 1'b0;
    in_i[0] = 16'h7FFF; in_i[1] = 16'h8000; shift_i = 4'd0; in_valid_i = 1'b1;
    repeat (65545) @(posedge clk_i);
    #1;
    chk("cnt_hold", longint'(sat_cnt_o), 65535);
    chk("cnt_hs_active", longint'(out_valid_o & sat_o[0]), 1);
    sat_clr_i = 1'b1;
    @(posedge clk_i); #1;
    sat_clr_i = 1'b0;
    chk("clr_wins", longint'(sat_cnt_o), 0);
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
